mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Parametrised multicycle control unit for the 16-bit MIPS core. It succeeds the fixed single-handshake controller.
- Adds bne, addi and j on top of the existing R-type/lw/sw/beq set.
- Adds a mem_ready wait handshake on every memory access.
- Adds a sticky illegal-instruction trap.
It drives every datapath strobe and sits between the instruction register decode fields and the datapath.

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, funct field width
ALUCTL_W, 3, ALUControl width
CNT_W, 16, width of optional performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
opcode  in  OP_W  instruction opcode from IR
funct  in  FUNCT_W  R-type function field from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
PCEn  out  1  PC register load enable
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegDst  out  1  write register select: 0 = rt, 1 = rd
MemtoReg  out  1  write data select: 0 = ALUOut, 1 = MDR
RegWrite  out  1  register file write
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = regA
ALUSrcB  out  2  ALU B select: 00 = regB, 01 = increment, 10 = signext imm, 11 = signext imm << 1
PCSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
ALUControl  out  ALUCTL_W  ALU operation
state_o  out  4  current state encoding, for debug
illegal  out  1  trap flag, sticky

Behaviour:
- Reset (rst=0, async): state=FETCH; all strobes 0; ALUControl=010; PCSrc=00; illegal=0. First FETCH cycle follows rst release.
- Outputs are a Moore decode of state, except:
  - PCEn and IRWrite are qualified by mem_ready in FETCH.
  - PCEn is qualified by zero in BEQ/BNE.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, BNEEX=9, ADDIEX=10, ADDIWB=11, JEX=12, TRAP=13; codes 14-15 go to FETCH.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00.
  - IRWrite=PCEn=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut).
  - Next state by opcode: 000000 -> RTYPEEX; 100011 or 101011 -> MEMADR; 000100 -> BEQEX; 000101 -> BNEEX; 001000 -> ADDIEX; 000010 -> JEX; any other -> TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: IorD=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1. MemWrite stays high while waiting; -> FETCH on mem_ready=1.
- RTYPEEX:
  - ALUSrcA=1, ALUSrcB=00.
  - funct decode: 100000 add=010; 100010 sub=110; 100100 and=000; 100101 or=001; 101010 slt=111.
  - Unknown funct -> TRAP; otherwise -> RTYPEWB.
- RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BEQEX / BNEEX:
  - ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01.
  - PCEn = zero (BEQ) or ~zero (BNE).
  - -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- JEX: PCSrc=10, PCEn=1 -> FETCH.
- TRAP:
  - illegal=1; all strobes 0.
  - Remains in TRAP until rst; mem_ready is ignored.
- mem_ready in non-memory states: ignored.
- Reset mid-access (e.g. in MEMWR): MemWrite drops asynchronously; no partial write is reissued.

Optional Feature:
Macro MC_CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0], both reset to 0.
  - cycle_cnt increments every cycle not in TRAP.
  - instr_cnt increments on each FETCH cycle with mem_ready=1.
  - Both wrap modulo 2^CNT_W.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg: state enumeration (4-bit); opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J); funct constants; ALU op codes; ALUSrcB and PCSrc encodings.
- One sub-module, mc_alu_decode: combinational funct-to-ALUControl plus a funct_valid flag, instantiated by the FSM.

Test Plan:
- Reset held 3 cycles, release with mem_ready=1 -> state_o=0, IRWrite=PCEn=1 in the first cycle, state_o=1 next, illegal=0.
- R-type add (opcode 000000, funct 100000), mem_ready=1:
  - states 0 -> 1 -> 6 -> 7 -> 0.
  - ALUControl=010 in RTYPEEX.
  - RegWrite=1 and RegDst=1 only in RTYPEWB.
- lw with mem_ready low 2 cycles in both FETCH and MEMRD:
  - FETCH held 3 cycles, IRWrite pulses once.
  - MEMRD held 3 cycles, IorD=1 throughout.
  - MEMWB: RegWrite=1, MemtoReg=1.
- beq with zero=1 -> PCEn=1, PCSrc=01 in BEQEX. bne with zero=1 -> PCEn=0. bne with zero=0 -> PCEn=1.
- Opcode 111111 -> TRAP after DECODE, illegal=1, all strobes 0 for 20 cycles despite mem_ready toggling. Reset clears it.
- sw with mem_ready held 0, rst asserted in MEMWR -> MemWrite falls without a clock edge, state_o=0. With MC_CTRL_PERF_CNT_EN defined: counters read 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// fields, ALU operations and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_BNEEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12,
        S_TRAP    = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_INC    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_alu_decode.sv
// R-type funct field to ALUControl decode; funct_valid_c flags unsupported functs.
module mc_alu_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUCTL_W = 3
) (
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUCTL_W-1:0] alu_ctl_c,
    output logic                funct_valid_c
);

    always_comb begin
        alu_ctl_c     = ALUCTL_W'(ALU_ADD);
        funct_valid_c = 1'b1;
        case (funct)
            FUNCT_W'(FN_ADD): alu_ctl_c = ALUCTL_W'(ALU_ADD);
            FUNCT_W'(FN_SUB): alu_ctl_c = ALUCTL_W'(ALU_SUB);
            FUNCT_W'(FN_AND): alu_ctl_c = ALUCTL_W'(ALU_AND);
            FUNCT_W'(FN_OR):  alu_ctl_c = ALUCTL_W'(ALU_OR);
            FUNCT_W'(FN_SLT): alu_ctl_c = ALUCTL_W'(ALU_SLT);
            default:          funct_valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the 16-bit MIPS core with memory wait handshake and
// sticky illegal-instruction trap. Define MC_CTRL_PERF_CNT_EN for cycle/instr counters.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OP_W     = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUCTL_W = 3
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCEn,
    output logic                IorD,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic [3:0]          state_o,
    output logic                illegal
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
`endif
);

    state_e               state_q, state_d;
    logic                 illegal_q, illegal_d;
    logic [ALUCTL_W-1:0]  alu_fn_c;
    logic                 funct_valid_c;

    mc_alu_decode #(
        .FUNCT_W  (FUNCT_W),
        .ALUCTL_W (ALUCTL_W)
    ) u_alu_decode (
        .funct         (funct),
        .alu_ctl_c     (alu_fn_c),
        .funct_valid_c (funct_valid_c)
    );

    // State and trap flag; reset clears both asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and Moore strobe decode.
    always_comb begin
        state_d    = state_q;
        PCEn       = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        PCSrc      = PCSRC_ALU;
        ALUControl = ALUCTL_W'(ALU_ADD);

        case (state_q)
            S_FETCH: begin
                ALUSrcB = SRCB_INC;
                // Reset sits in FETCH; keep the fetch strobes quiet until it is released.
                PCEn    = mem_ready & rst;
                IRWrite = mem_ready & rst;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                case (opcode)
                    OP_W'(OP_RTYPE):           state_d = S_RTYPEEX;
                    OP_W'(OP_LW), OP_W'(OP_SW): state_d = S_MEMADR;
                    OP_W'(OP_BEQ):             state_d = S_BEQEX;
                    OP_W'(OP_BNE):             state_d = S_BNEEX;
                    OP_W'(OP_ADDI):            state_d = S_ADDIEX;
                    OP_W'(OP_J):               state_d = S_JEX;
                    default:                   state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_RTYPEEX: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_fn_c;
                state_d    = funct_valid_c ? S_RTYPEWB : S_TRAP;
            end
            S_RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALUCTL_W'(ALU_SUB);
                PCSrc      = PCSRC_ALUOUT;
                PCEn       = zero;
                state_d    = S_FETCH;
            end
            S_BNEEX: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALUCTL_W'(ALU_SUB);
                PCSrc      = PCSRC_ALUOUT;
                PCEn       = ~zero;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                PCSrc   = PCSRC_JUMP;
                PCEn    = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    assign state_o = state_q;
    assign illegal = illegal_q;

`ifdef MC_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Free-running counters; both wrap naturally at 2^CNT_W.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != S_TRAP) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if ((state_q == S_FETCH) && mem_ready) instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes expected output vectors per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_mc_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  state_o;
    logic        illegal;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [15:0] cycle_cnt, instr_cnt;
`endif

    mc_ctrl_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .state_o    (state_o),
        .illegal    (illegal)
`ifdef MC_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: state | PCEn IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA | SrcB | PCSrc | ALU | illegal
    logic [19:0] act;
    assign act = {state_o, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, PCSrc, ALUControl, illegal};

    localparam logic [19:0] PCEN = 20'h08000;
    localparam logic [19:0] IORD = 20'h04000;
    localparam logic [19:0] MW   = 20'h02000;
    localparam logic [19:0] IRW  = 20'h01000;
    localparam logic [19:0] RD   = 20'h00800;
    localparam logic [19:0] M2R  = 20'h00400;
    localparam logic [19:0] RW   = 20'h00200;
    localparam logic [19:0] SA   = 20'h00100;
    localparam logic [19:0] ILL  = 20'h00001;
    localparam logic [19:0] M_SB = 20'h000C0;
    localparam logic [19:0] M_PS = 20'h00030;
    localparam logic [19:0] M_AL = 20'h0000E;
    localparam logic [19:0] M_BASE = 20'hF0000 | PCEN | MW | IRW | RW | ILL;

    localparam logic [5:0] O_R    = 6'b000000;
    localparam logic [5:0] O_LW   = 6'b100011;
    localparam logic [5:0] O_SW   = 6'b101011;
    localparam logic [5:0] O_BEQ  = 6'b000100;
    localparam logic [5:0] O_BNE  = 6'b000101;
    localparam logic [5:0] O_ADDI = 6'b001000;
    localparam logic [5:0] O_J    = 6'b000010;
    localparam logic [5:0] O_BAD  = 6'b111111;

    function automatic logic [19:0] st(input logic [3:0] s);   return {s, 16'h0}; endfunction
    function automatic logic [19:0] sb(input logic [1:0] x);   return {12'h0, x, 6'h0}; endfunction
    function automatic logic [19:0] ps(input logic [1:0] x);   return {14'h0, x, 4'h0}; endfunction
    function automatic logic [19:0] alu(input logic [2:0] x);  return {16'h0, x, 1'b0}; endfunction

    function automatic logic [19:0] f_fetch(input logic mr);
        return st(4'd0) | sb(2'b01) | alu(3'b010) | (mr ? (PCEN | IRW) : 20'h0);
    endfunction
    function automatic logic [19:0] f_br(input logic [3:0] s, input logic en);
        return st(s) | SA | sb(2'b00) | alu(3'b110) | ps(2'b01) | (en ? PCEN : 20'h0);
    endfunction

    // Fields each state defines explicitly; the rest are don't-care.
    function automatic logic [19:0] st_mask(input logic [3:0] s);
        case (s)
            4'd0:                 return M_BASE | IORD | SA | M_SB | M_PS | M_AL;
            4'd1, 4'd2, 4'd6,
            4'd10:                return M_BASE | SA | M_SB | M_AL;
            4'd3, 4'd5:           return M_BASE | IORD;
            4'd4, 4'd7, 4'd11:    return M_BASE | RD | M2R;
            4'd8, 4'd9:           return M_BASE | SA | M_SB | M_AL | M_PS;
            4'd12:                return M_BASE | M_PS;
            default:              return M_BASE;
        endcase
    endfunction

    int n_chk  = 0;
    int n_pass = 0;
    string       nm_q[$];
    logic [19:0] ex_q[$];
    logic [19:0] mk_q[$];

    task automatic chk(input string nm, input logic [19:0] a, input logic [19:0] e, input logic [19:0] m);
        n_chk++;
        if (((a ^ e) & m) == 20'h0) n_pass++;
        else $display("FAIL %s: got %05h expected %05h (mask %05h) at %0t", nm, a, e, m, $time);
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    string       mon_nm;
    logic [19:0] mon_ex, mon_mk;
    always @(negedge clk) begin
        if (ex_q.size() != 0) begin
            mon_nm = nm_q.pop_front();
            mon_ex = ex_q.pop_front();
            mon_mk = mk_q.pop_front();
            chk(mon_nm, act, mon_ex, mon_mk);
        end
    end

    task automatic cycm(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic mr, input logic [19:0] ex, input logic [19:0] mk);
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = mr;
        nm_q.push_back(nm);
        ex_q.push_back(ex);
        mk_q.push_back(mk);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic mr, input logic [19:0] ex);
        cycm(nm, op, fn, z, mr, ex, st_mask(ex[19:16]));
    endtask

    logic [5:0] fn_t  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] alu_t [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

    initial begin
        rst = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cyc("reset_hold", O_R, 6'h0, 1'b0, 1'b1, f_fetch(1'b0));
        rst = 1'b1;

        // R-type instructions, one per supported funct.
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("r%0d_fetch", i), O_R, fn_t[i], 1'b0, 1'b1, f_fetch(1'b1));
            cyc($sformatf("r%0d_dec", i),   O_R, fn_t[i], 1'b0, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
            cyc($sformatf("r%0d_ex", i),    O_R, fn_t[i], 1'b0, 1'b1, st(4'd6) | SA | sb(2'b00) | alu(alu_t[i]));
            cyc($sformatf("r%0d_wb", i),    O_R, fn_t[i], 1'b0, 1'b1, st(4'd7) | RD | RW);
        end

        // lw with two wait cycles in FETCH and in MEMRD.
        repeat (2) cyc("lw_fetch_wait", O_LW, 6'h0, 1'b0, 1'b0, f_fetch(1'b0));
        cyc("lw_fetch",   O_LW, 6'h0, 1'b0, 1'b1, f_fetch(1'b1));
        cyc("lw_dec",     O_LW, 6'h0, 1'b0, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
        cyc("lw_memadr",  O_LW, 6'h0, 1'b0, 1'b1, st(4'd2) | SA | sb(2'b10) | alu(3'b010));
        repeat (2) cyc("lw_memrd_wait", O_LW, 6'h0, 1'b0, 1'b0, st(4'd3) | IORD);
        cyc("lw_memrd",   O_LW, 6'h0, 1'b0, 1'b1, st(4'd3) | IORD);
        cyc("lw_memwb",   O_LW, 6'h0, 1'b0, 1'b1, st(4'd4) | M2R | RW);

        // Branches.
        cyc("beq1_fetch", O_BEQ, 6'h0, 1'b1, 1'b1, f_fetch(1'b1));
        cyc("beq1_dec",   O_BEQ, 6'h0, 1'b1, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
        cyc("beq1_ex",    O_BEQ, 6'h0, 1'b1, 1'b1, f_br(4'd8, 1'b1));
        cyc("beq0_fetch", O_BEQ, 6'h0, 1'b0, 1'b1, f_fetch(1'b1));
        cyc("beq0_dec",   O_BEQ, 6'h0, 1'b0, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
        cyc("beq0_ex",    O_BEQ, 6'h0, 1'b0, 1'b1, f_br(4'd8, 1'b0));
        cyc("bne1_fetch", O_BNE, 6'h0, 1'b1, 1'b1, f_fetch(1'b1));
        cyc("bne1_dec",   O_BNE, 6'h0, 1'b1, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
        cyc("bne1_ex",    O_BNE, 6'h0, 1'b1, 1'b1, f_br(4'd9, 1'b0));
        cyc("bne0_fetch", O_BNE, 6'h0, 1'b0, 1'b1, f_fetch(1'b1));
        cyc("bne0_dec",   O_BNE, 6'h0, 1'b0, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
        cyc("bne0_ex",    O_BNE, 6'h0, 1'b0, 1'b1, f_br(4'd9, 1'b1));

        // addi and j.
        cyc("addi_fetch", O_ADDI, 6'h0, 1'b0, 1'b1, f_fetch(1'b1));
        cyc("addi_dec",   O_ADDI, 6'h0, 1'b0, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
        cyc("addi_ex",    O_ADDI, 6'h0, 1'b0, 1'b1, st(4'd10) | SA | sb(2'b10) | alu(3'b010));
        cyc("addi_wb",    O_ADDI, 6'h0, 1'b0, 1'b1, st(4'd11) | RW);
        cyc("j_fetch",    O_J, 6'h0, 1'b0, 1'b1, f_fetch(1'b1));
        cyc("j_dec",      O_J, 6'h0, 1'b0, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
        cyc("j_ex",       O_J, 6'h0, 1'b0, 1'b1, st(4'd12) | ps(2'b10) | PCEN);

        // Unsupported funct traps after RTYPEEX.
        cyc("rbad_fetch", O_R, 6'b000111, 1'b0, 1'b1, f_fetch(1'b1));
        cyc("rbad_dec",   O_R, 6'b000111, 1'b0, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
        cycm("rbad_ex",   O_R, 6'b000111, 1'b0, 1'b1, st(4'd6) | SA, M_BASE | SA | M_SB);
        cyc("rbad_trap",  O_R, 6'b000111, 1'b0, 1'b1, st(4'd13) | ILL);
        rst = 1'b0;
        cyc("rbad_reset", O_R, 6'h0, 1'b0, 1'b1, f_fetch(1'b0));
        rst = 1'b1;

        // Illegal opcode: sticky trap regardless of inputs, cleared only by reset.
        cyc("bad_fetch", O_BAD, 6'h0, 1'b0, 1'b1, f_fetch(1'b1));
        cyc("bad_dec",   O_BAD, 6'h0, 1'b0, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
        for (int i = 0; i < 20; i++)
            cyc($sformatf("trap_%0d", i), (i % 3 == 0) ? O_LW : O_BAD, 6'h0, 1'(i % 2),
                1'((i + 1) % 2), st(4'd13) | ILL);
        rst = 1'b0;
        cyc("trap_reset", O_BAD, 6'h0, 1'b0, 1'b1, f_fetch(1'b0));
        rst = 1'b1;

        // sw stalled in MEMWR, then reset lands between clock edges.
        cyc("sw_fetch",  O_SW, 6'h0, 1'b0, 1'b1, f_fetch(1'b1));
        cyc("sw_dec",    O_SW, 6'h0, 1'b0, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));
        cyc("sw_memadr", O_SW, 6'h0, 1'b0, 1'b1, st(4'd2) | SA | sb(2'b10) | alu(3'b010));
        repeat (2) cyc("sw_memwr_wait", O_SW, 6'h0, 1'b0, 1'b0, st(4'd5) | IORD | MW);
        opcode = O_SW; mem_ready = 1'b0;
        #1;
        chk("sw_memwr_before_rst", act, st(4'd5) | IORD | MW, st_mask(4'd5));
        rst = 1'b0;
        #1;
        chk("sw_rst_async", act, f_fetch(1'b0), st_mask(4'd0));
`ifdef MC_CTRL_PERF_CNT_EN
        chk("cycle_cnt_rst", {4'h0, cycle_cnt}, 20'h0, 20'h0FFFF);
        chk("instr_cnt_rst", {4'h0, instr_cnt}, 20'h0, 20'h0FFFF);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("post_fetch", O_J, 6'h0, 1'b0, 1'b1, f_fetch(1'b1));
        cyc("post_dec",   O_J, 6'h0, 1'b0, 1'b1, st(4'd1) | sb(2'b11) | alu(3'b010));

        n_chk++;
        if (ex_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", ex_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
